// File: rtl/sbus_mem_ctl_pkg.sv
// Shared types for the SBUS memory controller slice: SBUS address/RQ fields,
// memory phase select, controller state and a word-count helper.
package sbus_mem_ctl_pkg;

  typedef logic [14:35] tSBUSAdr;
  typedef logic [0:3]   tRQ;

  typedef enum logic {PH_A, PH_B} tMemPhase;

  typedef enum logic [1:0] {IDLE, START, XFER, DONE} tCtlState;

  // Number of words requested by an RQ mask.
  function automatic logic [2:0] popcount4(input tRQ rq);
    popcount4 = 3'(rq[0]) + 3'(rq[1]) + 3'(rq[2]) + 3'(rq[3]);
  endfunction

endpackage

// File: rtl/sbus_mem_ctl_rr_arbiter.sv
// Round-robin arbiter: first requester at or after the pointer wins; the
// pointer moves past the winner only when the grant is actually taken.
module sbus_mem_ctl_rr_arbiter #(
  parameter int NREQ = 2
) (
  input  logic                     clk,
  input  logic                     CROBAR,
  input  logic [NREQ-1:0]          req,
  input  logic                     advance,
  output logic [NREQ-1:0]          gnt,
  output logic [$clog2(NREQ)-1:0]  gntId
);

  localparam int IDW = $clog2(NREQ);

  logic [IDW-1:0] rrPtr;
  logic           found;
  int unsigned    idx;

  // Priority scan starting at rrPtr, wrapping modulo NREQ.
  always_comb begin
    gnt   = '0;
    gntId = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = 32'(rrPtr) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req[IDW'(idx)]) begin
        found            = 1'b1;
        gnt[IDW'(idx)]   = 1'b1;
        gntId            = IDW'(idx);
      end
    end
  end

  // Pointer update: next search starts just after the granted requester.
  always_ff @(posedge clk) begin
    if (CROBAR)
      rrPtr <= '0;
    else if (advance && found)
      rrPtr <= (gntId == IDW'(NREQ-1)) ? '0 : gntId + 1'b1;
  end

endmodule

// File: rtl/sbus_mem_ctl.sv
// SBUS read-quadword sequencer: arbitrates requesters, issues START/ADR/RQ
// on the selected memory phase, returns data words with parity check and
// aborts with NXM when the memory stays silent too long.
module sbus_mem_ctl
  import sbus_mem_ctl_pkg::*;
#(
  parameter int NREQ       = 2,
  parameter int INTERLEAVE = 0,
  parameter int TIMEOUT    = 64
) (
  input  logic                     clk,
  input  logic                     CROBAR,
  input  logic [NREQ-1:0]          reqValid,
  input  logic [NREQ-1:0][14:35]   reqAdr,
  input  logic [NREQ-1:0][0:3]     reqRQ,
  output logic [NREQ-1:0]          reqGnt,
  output logic                     respValid,
  output logic [$clog2(NREQ)-1:0]  respId,
  output logic [1:0]               respWo,
  output logic [0:35]              respData,
  output logic                     respParErr,
  output logic                     respDone,
  output logic                     respNXM,
  output logic                     busy,
  output logic                     memStartA,
  output logic                     memStartB,
  output tSBUSAdr                  memAdr,
  output tRQ                       memRQ,
  input  logic                     memAcknA,
  input  logic                     memAcknB,
  input  logic                     memValidA,
  input  logic                     memValidB,
  input  logic [0:35]              memD,
  input  logic                     memPar
);

  localparam int IDW = $clog2(NREQ);
  localparam int TW  = $clog2(TIMEOUT);

  tCtlState        state;
  tMemPhase        phase;
  logic [1:0]      wo;
  logic [2:0]      vCnt;
  logic [2:0]      expected;
  logic [TW-1:0]   tCnt;

  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gntId;
  logic            advance;
  tSBUSAdr         selAdr;
  tRQ              selRQ;
  tMemPhase        selPh;
  logic            acknSel;
  logic            validSel;
  logic            hitV;
  logic            vLast;

  assign advance  = (state == IDLE) && (|reqValid);
  assign selAdr   = reqAdr[gntId];
  assign selRQ    = reqRQ[gntId];
  assign selPh    = ((INTERLEAVE != 0) && selAdr[33]) ? PH_B : PH_A;
  assign acknSel  = (phase == PH_B) ? memAcknB  : memAcknA;
  assign validSel = (phase == PH_B) ? memValidB : memValidA;

  // A VALID counts in START too, so a word arriving with ACKN is not lost.
  assign hitV  = ((state == START) || (state == XFER)) && validSel;
  assign vLast = hitV && ((vCnt + 3'd1) == expected);

  assign busy       = (state != IDLE);
  assign respValid  = hitV;
  assign respWo     = hitV ? wo : '0;
  assign respData   = hitV ? memD : '0;
  assign respParErr = hitV && (memPar != ^memD);

  sbus_mem_ctl_rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk     (clk),
    .CROBAR  (CROBAR),
    .req     (reqValid),
    .advance (advance),
    .gnt     (gnt),
    .gntId   (gntId)
  );

  // Controller FSM with registered grant, START/ADR/RQ and completion outputs.
  always_ff @(posedge clk) begin
    if (CROBAR) begin
      state     <= IDLE;
      phase     <= PH_A;
      wo        <= '0;
      vCnt      <= '0;
      expected  <= '0;
      tCnt      <= '0;
      reqGnt    <= '0;
      respId    <= '0;
      respDone  <= 1'b0;
      respNXM   <= 1'b0;
      memStartA <= 1'b0;
      memStartB <= 1'b0;
      memAdr    <= '0;
      memRQ     <= '0;
    end else begin
      reqGnt <= '0;
      case (state)
        IDLE: begin
          if (advance) begin
            reqGnt   <= gnt;
            respId   <= gntId;
            phase    <= selPh;
            wo       <= selAdr[34:35];
            vCnt     <= '0;
            tCnt     <= '0;
            expected <= popcount4(selRQ);
            if (selRQ == '0) begin
              state    <= DONE;
              respDone <= 1'b1;
              respNXM  <= 1'b0;
            end else begin
              state     <= START;
              memStartA <= (selPh == PH_A);
              memStartB <= (selPh == PH_B);
              memAdr    <= selAdr;
              memRQ     <= selRQ;
            end
          end
        end
        START, XFER: begin
          if (hitV) begin
            vCnt <= vCnt + 3'd1;
            wo   <= wo + 2'd1;
          end
          if (vLast) begin
            state     <= DONE;
            respDone  <= 1'b1;
            respNXM   <= 1'b0;
            memStartA <= 1'b0;
            memStartB <= 1'b0;
            memAdr    <= '0;
            memRQ     <= '0;
          end else if (hitV || acknSel) begin
            tCnt <= '0;
            if ((state == START) && acknSel) begin
              state     <= XFER;
              memStartA <= 1'b0;
              memStartB <= 1'b0;
              memAdr    <= '0;
              memRQ     <= '0;
            end
          end else if (tCnt == TW'(TIMEOUT-1)) begin
            state     <= DONE;
            respDone  <= 1'b1;
            respNXM   <= 1'b1;
            memStartA <= 1'b0;
            memStartB <= 1'b0;
            memAdr    <= '0;
            memRQ     <= '0;
          end else begin
            tCnt <= tCnt + 1'b1;
          end
        end
        DONE: begin
          respDone <= 1'b0;
          respNXM  <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sbus_mem_ctl.sv
// Bench for sbus_mem_ctl: a behavioural memory/requester model drives random
// cycles and checks grants, START handshake, returned words and completion.
module tb_sbus_mem_ctl;

  localparam int NREQ       = 2;
  localparam int INTERLEAVE = 1;
  localparam int TIMEOUT    = 64;
  localparam int IDW        = $clog2(NREQ);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   CROBAR;
  logic [NREQ-1:0]        reqValid;
  logic [NREQ-1:0][14:35] reqAdr;
  logic [NREQ-1:0][0:3]   reqRQ;
  logic [NREQ-1:0]        reqGnt;
  logic                   respValid;
  logic [IDW-1:0]         respId;
  logic [1:0]             respWo;
  logic [0:35]            respData;
  logic                   respParErr, respDone, respNXM, busy;
  logic                   memStartA, memStartB;
  logic [14:35]           memAdr;
  logic [0:3]             memRQ;
  logic                   memAcknA, memAcknB, memValidA, memValidB;
  logic [0:35]            memD;
  logic                   memPar;

  int n_cmp = 0;
  int n_err = 0;
  int model_ptr = 0;

  sbus_mem_ctl #(.NREQ(NREQ), .INTERLEAVE(INTERLEAVE), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .CROBAR(CROBAR), .reqValid(reqValid), .reqAdr(reqAdr), .reqRQ(reqRQ),
    .reqGnt(reqGnt), .respValid(respValid), .respId(respId), .respWo(respWo),
    .respData(respData), .respParErr(respParErr), .respDone(respDone), .respNXM(respNXM),
    .busy(busy), .memStartA(memStartA), .memStartB(memStartB), .memAdr(memAdr),
    .memRQ(memRQ), .memAcknA(memAcknA), .memAcknB(memAcknB), .memValidA(memValidA),
    .memValidB(memValidB), .memD(memD), .memPar(memPar)
  );

  function automatic logic start_of(input int ph);
    return (ph != 0) ? memStartB : memStartA;
  endfunction

  // Round-robin rule: first requester at or after the one following the last winner.
  function automatic int pick(input logic [NREQ-1:0] want);
    for (int k = 0; k < NREQ; k++) begin
      int j;
      j = (model_ptr + k) % NREQ;
      if (want[j]) return j;
    end
    return 0;
  endfunction

  task automatic clear_mem();
    memAcknA = 0; memAcknB = 0; memValidA = 0; memValidB = 0; memD = '0; memPar = 0;
  endtask

  task automatic test_reset();
    CROBAR = 1; reqValid = '0; reqAdr = '0; reqRQ = '0; clear_mem();
    repeat (2) @(negedge clk);
    n_cmp++; if (busy !== 0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if ({memStartA, memStartB} !== 2'b00) begin n_err++; $display("FAIL reset_start: got %b want 00", {memStartA, memStartB}); end
    n_cmp++; if ({reqGnt, respDone, respNXM, respValid} !== '0) begin n_err++; $display("FAIL reset_pulses: got %b want 0", {reqGnt, respDone, respNXM, respValid}); end
    n_cmp++; if ({memAdr, memRQ, respId} !== '0) begin n_err++; $display("FAIL reset_regs: got %h want 0", {memAdr, memRQ, respId}); end
    CROBAR = 0;
    model_ptr = 0;
  endtask

  // One full memory cycle for the model-chosen winner among 'want'.
  task automatic run_cycle(input logic [NREQ-1:0] want, input int ack_dly, input int flip_word, input bit keep);
    int w, nw, ph, wo, k, step, gap;
    bit acked, ack_now, v_now, flip;
    logic [21:0] adr;
    logic [3:0] rq;
    logic [0:35] d;
    w = pick(want);
    adr = reqAdr[w];
    rq = reqRQ[w];
    nw = $countones(rq);
    ph = (INTERLEAVE != 0) ? int'(adr[2]) : 0;
    wo = int'(adr[1:0]);
    reqValid = reqValid | want;
    k = 0;
    do begin @(negedge clk); k++; end while (reqGnt == '0 && k < 4*NREQ);
    n_cmp++; if (reqGnt !== NREQ'(1 << w)) begin n_err++; $display("FAIL grant: got %b want %b", reqGnt, NREQ'(1 << w)); end
    model_ptr = (w + 1) % NREQ;
    if (!keep) reqValid = '0;
    if (nw == 0) begin
      n_cmp++; if ({respDone, respNXM, memStartA, memStartB} !== 4'b1000) begin n_err++; $display("FAIL rq0_done: got %b want 1000", {respDone, respNXM, memStartA, memStartB}); end
      @(negedge clk);
      n_cmp++; if ({respDone, busy} !== 2'b00) begin n_err++; $display("FAIL rq0_idle: got %b want 00", {respDone, busy}); end
      return;
    end
    acked = 0; k = 0; step = 0; gap = 0;
    while (k < nw && step < 200) begin
      n_cmp++; if ({start_of(ph), start_of(1 - ph)} !== {!acked, 1'b0}) begin n_err++; $display("FAIL start: got %b want %b", {start_of(ph), start_of(1 - ph)}, {!acked, 1'b0}); end
      if (!acked) begin
        n_cmp++; if ({memAdr, memRQ} !== {adr, rq}) begin n_err++; $display("FAIL adr_rq: got %h want %h", {memAdr, memRQ}, {adr, rq}); end
      end
      ack_now = !acked && (step == ack_dly);
      v_now = (acked || ack_now) && (($urandom_range(0, 1) == 1) || gap >= 6);
      flip = v_now && (k == flip_word);
      d = {4'($urandom), $urandom};
      if (ph != 0) begin
        memAcknB = ack_now; memValidB = v_now; memAcknA = 1'($urandom); memValidA = 1'($urandom);
      end else begin
        memAcknA = ack_now; memValidA = v_now; memAcknB = 1'($urandom); memValidB = 1'($urandom);
      end
      memD = d; memPar = (^d) ^ flip;
      #1;
      n_cmp++; if (respValid !== v_now) begin n_err++; $display("FAIL respValid: got %b want %b", respValid, v_now); end
      if (v_now) begin
        n_cmp++; if (respWo !== 2'(wo)) begin n_err++; $display("FAIL respWo: got %0d want %0d", respWo, wo); end
        n_cmp++; if (respData !== d) begin n_err++; $display("FAIL respData: got %h want %h", respData, d); end
        n_cmp++; if (respParErr !== flip) begin n_err++; $display("FAIL respParErr: got %b want %b", respParErr, flip); end
      end
      if (ack_now) acked = 1;
      if (v_now) begin k++; wo = (wo + 1) % 4; gap = 0; end else gap++;
      step++;
      @(negedge clk);
    end
    clear_mem();
    n_cmp++; if (k !== nw) begin n_err++; $display("FAIL xfer_words: got %0d want %0d", k, nw); end
    n_cmp++; if ({respDone, respNXM, memStartA, memStartB} !== 4'b1000) begin n_err++; $display("FAIL done: got %b want 1000", {respDone, respNXM, memStartA, memStartB}); end
    n_cmp++; if (respId !== IDW'(w)) begin n_err++; $display("FAIL respId: got %0d want %0d", respId, w); end
    @(negedge clk);
    n_cmp++; if ({respDone, busy} !== 2'b00) begin n_err++; $display("FAIL done_idle: got %b want 00", {respDone, busy}); end
  endtask

  task automatic test_single();
    reqAdr[0] = 22'o1000; reqRQ[0] = 4'b1111;
    run_cycle(2'b01, 2, -1, 0);
  endtask

  task automatic test_req1();
    reqAdr[1] = 22'o1002; reqRQ[1] = 4'b1100;
    run_cycle(2'b10, 1, -1, 0);
  endtask

  task automatic test_parity();
    reqAdr[0] = 22'o2004; reqRQ[0] = 4'b1111;
    run_cycle(2'b01, 0, 1, 0);
  endtask

  task automatic test_back_to_back();
    reqAdr[0] = 22'o3000; reqRQ[0] = 4'b0100;
    reqAdr[1] = 22'o3005; reqRQ[1] = 4'b0011;
    for (int i = 0; i < 6; i++) run_cycle(2'b11, $urandom_range(0, 3), -1, 1);
    reqValid = '0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++) begin
      for (int r = 0; r < NREQ; r++) begin
        reqAdr[r] = 22'($urandom);
        reqRQ[r] = 4'($urandom_range(0, 15));
      end
      run_cycle(NREQ'($urandom_range(1, 3)), $urandom_range(0, 5), $urandom_range(0, 4), 0);
    end
  endtask

  task automatic test_nxm();
    int k, cnt, ph;
    bit stray;
    reqAdr[0] = 22'o4004; reqRQ[0] = 4'b1010;
    ph = (INTERLEAVE != 0) ? 1 : 0;
    reqValid = 2'b01;
    k = 0;
    do begin @(negedge clk); k++; end while (reqGnt == '0 && k < 4*NREQ);
    n_cmp++; if (reqGnt !== 2'b01) begin n_err++; $display("FAIL nxm_grant: got %b want 01", reqGnt); end
    reqValid = '0;
    model_ptr = 1;
    cnt = 0; k = 0;
    while (start_of(ph) === 1'b1 && k < 100) begin
      cnt++;
      if (ph != 0) memAcknA = 1; else memAcknB = 1;
      if (k == 10) reqValid[1] = 1;
      if (k == 20) reqValid[1] = 0;
      @(negedge clk);
      k++;
    end
    clear_mem();
    n_cmp++; if (cnt !== TIMEOUT) begin n_err++; $display("FAIL nxm_start_len: got %0d want %0d", cnt, TIMEOUT); end
    n_cmp++; if ({respDone, respNXM} !== 2'b11) begin n_err++; $display("FAIL nxm_done: got %b want 11", {respDone, respNXM}); end
    if (ph != 0) memValidB = 1; else memValidA = 1;
    #1;
    n_cmp++; if (respValid !== 0) begin n_err++; $display("FAIL nxm_late_valid: got %b want 0", respValid); end
    @(negedge clk);
    clear_mem();
    n_cmp++; if ({respDone, respNXM, busy} !== 3'b000) begin n_err++; $display("FAIL nxm_idle: got %b want 000", {respDone, respNXM, busy}); end
    stray = 0;
    repeat (5) begin @(negedge clk); if (reqGnt != '0 || busy) stray = 1; end
    n_cmp++; if (stray !== 0) begin n_err++; $display("FAIL dropped_req_granted: got %b want 0", stray); end
    reqAdr[1] = 22'o5001; reqRQ[1] = 4'b0110;
    run_cycle(2'b10, 0, -1, 0);
  endtask

  task automatic test_reset_mid();
    int k;
    bit seen;
    reqAdr[0] = 22'o1000; reqRQ[0] = 4'b1111;
    reqValid = 2'b01;
    k = 0;
    do begin @(negedge clk); k++; end while (reqGnt == '0 && k < 4*NREQ);
    n_cmp++; if (reqGnt !== 2'b01) begin n_err++; $display("FAIL rst_grant: got %b want 01", reqGnt); end
    reqValid = '0;
    memAcknA = 1;
    @(negedge clk);
    memAcknA = 0; memValidA = 1; memD = 36'h123456789; memPar = ^memD;
    @(negedge clk);
    memD = 36'h0abcdef01; memPar = ^memD;
    @(negedge clk);
    clear_mem();
    CROBAR = 1;
    @(negedge clk);
    memValidA = 1;
    #1;
    n_cmp++; if ({busy, memStartA, memStartB, respDone, respNXM, respValid, reqGnt} !== '0) begin n_err++; $display("FAIL rst_mid_ctl: got %b want 0", {busy, memStartA, memStartB, respDone, respNXM, respValid, reqGnt}); end
    n_cmp++; if ({memAdr, memRQ, respId, respWo, respData} !== '0) begin n_err++; $display("FAIL rst_mid_data: got %h want 0", {memAdr, memRQ, respId, respWo, respData}); end
    CROBAR = 0;
    clear_mem();
    model_ptr = 0;
    seen = 0;
    repeat (6) begin @(negedge clk); if (respDone || busy) seen = 1; end
    n_cmp++; if (seen !== 0) begin n_err++; $display("FAIL rst_mid_quiet: got %b want 0", seen); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_reset_mid();
    test_req1();
    test_parity();
    test_back_to_back();
    test_random();
    test_nxm();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
